// File: rtl/shared_reg_arb.sv
// Round-robin arbitrated shared register with bounded lock/hold; grant is registered, write lands on the grant edge.
// Request-to-grant 1 cycle when free, grant-to-write 0 cycles; a granted requester dropping req_i loses the grant with no write.
module shared_reg_arb #(
  parameter int NUM_REQ  = 4,
  parameter int DATA_W   = 8,
  parameter int MAX_HOLD = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ-1:0]        lock_i,
  input  logic [NUM_REQ*DATA_W-1:0] data_i,
  output logic [NUM_REQ-1:0]        gnt_o,
  output logic [DATA_W-1:0]         q_o,
  output logic                      q_valid_o,
  output logic [IDX_W-1:0]          q_src_o,
  output logic                      busy_o
);

  logic [IDX_W-1:0]   ptr;
  logic [3:0]         hold_cnt;

  logic               owner_vld;
  logic [IDX_W-1:0]   owner_idx;
  logic               owner_req;
  logic               owner_lock;
  logic [DATA_W-1:0]  wr_dat;
  logic               wr_en;
  logic               hold_en;

  logic [NUM_REQ-1:0] cand;
  logic               win_vld;
  logic [IDX_W-1:0]   win_idx;
  logic [NUM_REQ-1:0] win_gnt;
  logic [IDX_W-1:0]   ptr_nxt;
  logic [IDX_W:0]     sum;
  logic [IDX_W-1:0]   pos;

  // Decode the current owner from the one-hot grant.
  always_comb begin
    owner_vld  = |gnt_o;
    owner_idx  = '0;
    owner_req  = 1'b0;
    owner_lock = 1'b0;
    wr_dat     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt_o[k]) begin
        owner_idx  = IDX_W'(k);
        owner_req  = req_i[k];
        owner_lock = lock_i[k];
        wr_dat     = data_i[k*DATA_W +: DATA_W];
      end
    end
  end

  assign wr_en   = owner_vld && owner_req;
  assign hold_en = wr_en && owner_lock && (hold_cnt < 4'(MAX_HOLD - 1));

  // A releasing owner is only a candidate when nobody else is asking.
  always_comb begin
    cand = req_i;
    if (owner_vld && ((req_i & ~gnt_o) != '0))
      cand = req_i & ~gnt_o;
    win_vld = 1'b0;
    win_idx = '0;
    sum     = '0;
    pos     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, ptr} + (IDX_W+1)'(i);
      if (sum >= (IDX_W+1)'(NUM_REQ))
        sum = sum - (IDX_W+1)'(NUM_REQ);
      pos = sum[IDX_W-1:0];
      if (!win_vld && cand[pos]) begin
        win_vld = 1'b1;
        win_idx = pos;
      end
    end
  end

  assign win_gnt = win_vld ? (NUM_REQ'(1) << win_idx) : '0;
  assign ptr_nxt = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
  assign busy_o  = |gnt_o;

  always_ff @(posedge clk) begin
    if (reset) begin
      gnt_o     <= '0;
      q_o       <= '0;
      q_valid_o <= 1'b0;
      q_src_o   <= '0;
      ptr       <= '0;
      hold_cnt  <= '0;
    end else begin
      if (wr_en) begin
        q_o       <= wr_dat;
        q_src_o   <= owner_idx;
        q_valid_o <= 1'b1;
      end else begin
        q_valid_o <= 1'b0;
      end
      if (hold_en) begin
        hold_cnt <= hold_cnt + 4'd1;
      end else begin
        gnt_o    <= win_gnt;
        hold_cnt <= '0;
        if (win_vld)
          ptr <= ptr_nxt;
      end
    end
  end

endmodule

// File: doc/shared_reg_arb.md
SHARED_REG_ARB -- requirements
Module: shared_reg_arb

Interface
REQ-001 Parameter NUM_REQ, default 4, is the number of requesters; legal range 2..16.
REQ-002 Parameter DATA_W, default 8, is the width of the shared register.
REQ-003 Parameter MAX_HOLD, default 4, is the maximum number of consecutive cycles one requester may hold the grant; legal range 1..15.
REQ-004 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1 bit: reset, synchronous and active-high.
REQ-006 Port req_i, input, NUM_REQ bits: bit k high means requester k wants to write the shared register.
REQ-007 Port lock_i, input, NUM_REQ bits: bit k high means requester k asks to keep its grant for further cycles.
REQ-008 Port data_i, input, NUM_REQ*DATA_W bits: slice [k*DATA_W +: DATA_W] is requester k's write data.
REQ-009 Port gnt_o, output, NUM_REQ bits: registered grant, one-hot or zero.
REQ-010 Port q_o, output, DATA_W bits: shared register contents.
REQ-011 Port q_valid_o, output, 1 bit: pulses high for one cycle after each write to q_o.
REQ-012 Port q_src_o, output, $clog2(NUM_REQ) bits: index of the requester that performed the last write.
REQ-013 Port busy_o, output, 1 bit: OR of gnt_o.

Function
REQ-014 gnt_o SHALL never have more than one bit set.
REQ-015 Write: at a rising edge where gnt_o[k] and req_i[k] are both high, q_o SHALL load slice k of data_i, q_src_o SHALL load k and q_valid_o SHALL go high; otherwise q_valid_o SHALL go low and q_o and q_src_o SHALL hold.
REQ-016 A granted requester whose req_i is low at the edge SHALL write nothing and SHALL lose the grant at that edge.
REQ-017 Hold: the grant of requester k SHALL be kept when gnt_o[k], req_i[k] and lock_i[k] are all high and hold_cnt < MAX_HOLD-1; hold_cnt then increments by 1.
REQ-018 Release/arbitrate: in every other case, gnt_o SHALL load the one-hot of the winner at that edge (all zero if req_i is zero), and hold_cnt SHALL load 0.
REQ-019 Winner: the first set bit of req_i, searching upward with wrap-around from index ptr.
REQ-020 ptr: a round-robin pointer that SHALL load (winner+1) mod NUM_REQ whenever a winner is granted, and SHALL otherwise hold.
REQ-021 A releasing owner that still requests SHALL have lowest priority at the release edge, and SHALL be regranted only if no other request bit is set.
REQ-022 There SHALL be no idle bubble between owners: release of one grant and issue of the next SHALL occur on the same edge.
REQ-023 Request-to-grant latency SHALL be 1 cycle when the arbiter is free, and grant-to-write latency SHALL be 0 cycles.
REQ-024 Maximum hold: an owner holding lock_i continuously SHALL receive exactly MAX_HOLD consecutive grant cycles; MAX_HOLD=1 means lock_i has no effect.
REQ-025 Changes on lock_i or data_i of non-granted requesters SHALL have no effect on any output.

Reset
REQ-026 While reset is high at a rising edge: gnt_o=0, q_o=0, q_valid_o=0, q_src_o=0, ptr=0, hold_cnt=0.
REQ-027 Reset SHALL override an in-progress hold and any simultaneous write, with no write occurring at that edge.
REQ-028 After reset deasserts, the first grant SHALL follow REQ-019 with ptr=0.

Verification
REQ-029 All four req_i bits held high, lock_i=0 -> gnt_o cycles 0001, 0010, 0100, 1000, 0001 on consecutive cycles; q_src_o follows 0,1,2,3 one cycle later.
REQ-030 req_i=0001 with lock_i=0001 held, and req_i[2] high from the same cycle -> gnt_o=0001 for exactly 4 cycles, then 0100; q_valid_o stays high throughout.
REQ-031 Grant 0010 issued, then req_i[1] dropped in the granted cycle -> no write (q_valid_o=0, q_o unchanged); gnt_o goes to the next requester or to 0.
REQ-032 Reset asserted during a hold at hold_cnt=2 -> next cycle gnt_o=0, q_o=0, q_valid_o=0; after release with req_i=1010 -> gnt_o=0010.
REQ-033 Single requester 3 with lock_i=0 and req held -> gnt_o=1000 continuously (regranted each edge), with q_o tracking data_i slice 3 one cycle late.
REQ-034 Every cycle of every test -> gnt_o is one-hot or zero, and busy_o equals |gnt_o.
